// File: rtl/counter_run_if.sv
// Bus bundle between the run controller and its environment: raw button,
// counter feedback and the controller's run/status outputs.
interface counter_run_if #(
   parameter int unsigned N = 8
);
   logic         btn;
   logic [N-1:0] count_in;
   logic         start;
   logic         busy;
   logic         done;
   logic         aborted;
   logic [7:0]   runs;

   modport master (
      output btn, count_in,
      input  start, busy, done, aborted, runs
   );

   modport slave (
      input  btn, count_in,
      output start, busy, done, aborted, runs
   );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for a free-running counter: debounced push-button start/abort,
// automatic stop at LIMIT, done pulse, sticky abort flag and saturating run tally.
module counter_run_ctrl #(
   parameter int unsigned N          = 8,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned LIMIT      = 200
) (
   input logic          clk,
   input logic          rst_n,
   counter_run_if.slave bus
);

   localparam int unsigned DEB_W    = 8;
   localparam int unsigned RUNS_W   = 8;
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [N-1:0]      LIMIT_VAL = N'(LIMIT);
   localparam logic [RUNS_W-1:0] RUNS_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic               s1;
   logic               s2;
   logic               btn_db;
   logic               btn_db_d;
   logic [DEB_W-1:0]   deb_cnt;
   logic               press_c;
   logic               start_q;
   logic               busy_q;
   logic               done_q;
   logic               aborted_q;
   logic               aborted_nx;
   logic [RUNS_W-1:0]  runs_q;
   logic [RUNS_W-1:0]  runs_nx;

   // Two-flop synchronizer followed by a stability-count debouncer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
         deb_cnt  <= '0;
      end else begin
         s1       <= bus.btn;
         s2       <= s1;
         btn_db_d <= btn_db;
         if (s2 == btn_db) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   assign press_c = btn_db & ~btn_db_d;

   // Next-state and next-status decode; limit match outranks an abort press.
   always_comb begin
      state_nx   = state;
      aborted_nx = aborted_q;
      runs_nx    = runs_q;
      unique case (state)
         IDLE: begin
            if (press_c) begin
               state_nx   = RUN;
               aborted_nx = 1'b0;
            end
         end
         RUN: begin
            if (bus.count_in == LIMIT_VAL) begin
               state_nx = DONE;
               if (runs_q != RUNS_MAX) begin
                  runs_nx = runs_q + RUNS_W'(1);
               end
            end else if (press_c) begin
               state_nx   = ABORT;
               aborted_nx = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         ABORT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and registered outputs, decoded from next-state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         runs_q    <= '0;
      end else begin
         state     <= state_nx;
         start_q   <= (state_nx == RUN);
         busy_q    <= (state_nx == RUN);
         done_q    <= (state_nx == DONE);
         aborted_q <= aborted_nx;
         runs_q    <= runs_nx;
      end
   end

   assign bus.start   = start_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;
   assign bus.runs    = runs_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: directed and random button stimulus against a
// behavioural model, plus a LIMIT=1 instance for run-tally saturation.
module tb_counter_run_ctrl;

   localparam int unsigned N     = 8;
   localparam int unsigned DEB   = 4;
   localparam int unsigned LIM_A = 200;
   localparam int unsigned LIM_B = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic [N-1:0] cnt_a;
   logic [N-1:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   counter_run_if #(.N(N)) bus_a ();
   counter_run_if #(.N(N)) bus_b ();

   counter_run_ctrl #(.N(N), .DEB_CYCLES(DEB), .LIMIT(LIM_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
   );
   counter_run_ctrl #(.N(N), .DEB_CYCLES(DEB), .LIMIT(LIM_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
   );

   assign bus_a.btn      = btn;
   assign bus_b.btn      = btn;
   assign bus_a.count_in = cnt_a;
   assign bus_b.count_in = cnt_b;

   // Downstream counters: count while start is high, clear otherwise.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         cnt_a <= bus_a.start ? cnt_a + 8'd1 : 8'd0;
         cnt_b <= bus_b.start ? cnt_b + 8'd1 : 8'd0;
      end
   end

   // Behavioural model of the LIMIT=200 instance.
   bit       m_s1, m_s2, m_db, m_rose;
   int       m_diff;
   bit       m_run, m_done, m_ab, m_abt;
   bit [7:0] m_runs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_db = 0; m_rose = 0; m_diff = 0;
         m_run = 0; m_done = 0; m_ab = 0; m_abt = 0; m_runs = 8'd0;
      end else begin
         bit p;
         p = m_rose;
         m_rose = 0;
         if (m_s2 != m_db) begin
            m_diff++;
            if (m_diff == int'(DEB)) begin
               m_db   = m_s2;
               m_diff = 0;
               m_rose = m_db;
            end
         end else begin
            m_diff = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn;
         if (m_done || m_ab) begin
            m_done = 0;
            m_ab   = 0;
         end else if (m_run) begin
            if (cnt_a == 8'(LIM_A)) begin
               m_run  = 0;
               m_done = 1;
               if (m_runs < 8'd255) m_runs = m_runs + 8'd1;
            end else if (p) begin
               m_run = 0;
               m_ab  = 1;
               m_abt = 1;
            end
         end else if (p) begin
            m_run = 1;
            m_abt = 0;
         end
      end
   end

   logic [11:0] obs_a, exp_a, obs_b;
   assign obs_a = {bus_a.start, bus_a.busy, bus_a.done, bus_a.aborted, bus_a.runs};
   assign obs_b = {bus_b.start, bus_b.busy, bus_b.done, bus_b.aborted, bus_b.runs};
   assign exp_a = {m_run, m_run, m_done, m_abt, m_runs};

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      int guard;
      rst_n = 1'b0; btn = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (obs_a !== 12'h000) begin n_fail++; $display("FAIL reset_a: got %h expected 000", obs_a); end
      n_tests++; if (obs_b !== 12'h000) begin n_fail++; $display("FAIL reset_b: got %h expected 000", obs_b); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b1; repeat (8) @(negedge clk); btn = 1'b0;
      guard = 0;
      while (cnt_a != 8'd37 && guard < 200) begin @(negedge clk); guard++; end
      n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL reset_wait37: got count %0d expected 37", cnt_a); end
      n_tests++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL reset_midrun_busy: got %b expected 1", bus_a.busy); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (obs_a !== 12'h000) begin n_fail++; $display("FAIL reset_async: got %h expected 000", obs_a); end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (obs_a !== 12'h000) begin n_fail++; $display("FAIL reset_idle: got %h expected 000", obs_a); end
      n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
   endtask

   task automatic test_debounce();
      logic e;
      int guard;
      btn = 1'b0; repeat (10) @(negedge clk);
      btn = 1'b1; repeat (3) @(negedge clk); btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_tests++;
         if (bus_a.start !== 1'b0 || obs_a !== exp_a) begin
            n_fail++; $display("FAIL glitch cyc %0d: got %h expected %h (start 0)", i, obs_a, exp_a);
         end
      end
      btn = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         @(posedge clk); #1;
         e = (i == 6);
         n_tests++;
         if (bus_a.start !== e) begin n_fail++; $display("FAIL deb_timing edge k+%0d: got %b expected %b", i, bus_a.start, e); end
      end
      repeat (4) @(negedge clk); btn = 1'b0;
      guard = 0;
      while (bus_a.done !== 1'b1 && guard < 300) begin
         @(negedge clk); guard++;
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL deb_run_model: got %h expected %h", obs_a, exp_a); end
      end
      n_tests++; if (guard >= 300) begin n_fail++; $display("FAIL deb_run_done: got no done expected done"); end
   endtask

   task automatic test_normal_run();
      logic [7:0] r0, max_cnt;
      int done_cyc;
      btn = 1'b0; repeat (10) @(negedge clk);
      r0 = bus_a.runs; max_cnt = 8'd0; done_cyc = 0;
      btn = 1'b1;
      for (int i = 0; i < 260; i++) begin
         if (i == 10) btn = 1'b0;
         @(negedge clk);
         if (bus_a.busy === 1'b1 && cnt_a > max_cnt) max_cnt = cnt_a;
         if (bus_a.done === 1'b1) done_cyc++;
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL run_model cyc %0d: got %h expected %h", i, obs_a, exp_a); end
      end
      n_tests++; if (done_cyc != 1) begin n_fail++; $display("FAIL run_done_width: got %0d expected 1", done_cyc); end
      n_tests++; if (max_cnt !== 8'(LIM_A)) begin n_fail++; $display("FAIL run_max_count: got %0d expected %0d", max_cnt, LIM_A); end
      n_tests++; if (bus_a.runs !== 8'(r0 + 8'd1)) begin n_fail++; $display("FAIL run_tally: got %0d expected %0d", bus_a.runs, r0 + 8'd1); end
      n_tests++; if (bus_a.start !== 1'b0 || bus_a.aborted !== 1'b0) begin
         n_fail++; $display("FAIL run_end_state: got start %b aborted %b expected 0 0", bus_a.start, bus_a.aborted);
      end
   endtask

   task automatic test_abort();
      logic [7:0] r0;
      int guard;
      btn = 1'b0; repeat (10) @(negedge clk);
      r0 = bus_a.runs;
      btn = 1'b1; repeat (8) @(negedge clk); btn = 1'b0;
      guard = 0;
      while (cnt_a != 8'd50 && guard < 200) begin
         @(negedge clk); guard++;
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL abort_model: got %h expected %h", obs_a, exp_a); end
      end
      n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL abort_wait50: got count %0d expected 50", cnt_a); end
      btn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) btn = 1'b0;
         @(negedge clk);
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL abort_press_model: got %h expected %h", obs_a, exp_a); end
      end
      n_tests++; if (bus_a.aborted !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.start !== 1'b0) begin
         n_fail++; $display("FAIL abort_flags: got aborted %b busy %b start %b expected 1 0 0", bus_a.aborted, bus_a.busy, bus_a.start);
      end
      n_tests++; if (bus_a.runs !== r0) begin n_fail++; $display("FAIL abort_tally: got %0d expected %0d", bus_a.runs, r0); end
      repeat (4) @(negedge clk);
      btn = 1'b1; repeat (8) @(negedge clk); btn = 1'b0;
      n_tests++; if (bus_a.aborted !== 1'b0 || bus_a.busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_restart: got aborted %b busy %b expected 0 1", bus_a.aborted, bus_a.busy);
      end
      guard = 0;
      while (bus_a.done !== 1'b1 && guard < 300) begin
         @(negedge clk); guard++;
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL abort_rerun_model: got %h expected %h", obs_a, exp_a); end
      end
      n_tests++; if (bus_a.runs !== 8'(r0 + 8'd1)) begin n_fail++; $display("FAIL abort_rerun_tally: got %0d expected %0d", bus_a.runs, r0 + 8'd1); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] r0;
      int guard, done_cyc;
      btn = 1'b0; repeat (10) @(negedge clk);
      r0 = bus_a.runs;
      btn = 1'b1; repeat (8) @(negedge clk); btn = 1'b0;
      guard = 0;
      while (cnt_a != 8'(LIM_A - 6) && guard < 300) begin @(negedge clk); guard++; end
      n_tests++; if (guard >= 300) begin n_fail++; $display("FAIL simul_wait: got count %0d expected %0d", cnt_a, LIM_A - 6); end
      btn = 1'b1; done_cyc = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 20) btn = 1'b0;
         @(negedge clk);
         if (bus_a.done === 1'b1) done_cyc++;
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL simul_model cyc %0d: got %h expected %h", i, obs_a, exp_a); end
      end
      n_tests++; if (done_cyc != 1) begin n_fail++; $display("FAIL simul_done: got %0d expected 1", done_cyc); end
      n_tests++; if (bus_a.aborted !== 1'b0 || bus_a.busy !== 1'b0) begin
         n_fail++; $display("FAIL simul_flags: got aborted %b busy %b expected 0 0", bus_a.aborted, bus_a.busy);
      end
      n_tests++; if (bus_a.runs !== 8'(r0 + 8'd1)) begin n_fail++; $display("FAIL simul_tally: got %0d expected %0d", bus_a.runs, r0 + 8'd1); end
   endtask

   task automatic test_random();
      int seg;
      seg = 0;
      btn = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            btn = ~btn;
            if ($urandom_range(0, 3) == 0) seg = int'($urandom_range(1, 3));
            else seg = int'($urandom_range(4, 250));
         end
         seg--;
         @(negedge clk);
         n_tests++; if (obs_a !== exp_a) begin n_fail++; $display("FAIL random_model cyc %0d: got %h expected %h", i, obs_a, exp_a); end
      end
   endtask

   task automatic test_saturation();
      int busy_cyc, done_cyc;
      logic [7:0] exp_runs;
      rst_n = 1'b0; btn = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      for (int r = 1; r <= 256; r++) begin
         busy_cyc = 0; done_cyc = 0;
         btn = 1'b1;
         for (int c = 0; c < 20; c++) begin
            if (c == 10) btn = 1'b0;
            @(negedge clk);
            if (bus_b.busy === 1'b1) busy_cyc++;
            if (bus_b.done === 1'b1) done_cyc++;
         end
         exp_runs = (r > 255) ? 8'd255 : 8'(r);
         n_tests++; if (bus_b.runs !== exp_runs) begin n_fail++; $display("FAIL sat_runs run %0d: got %0d expected %0d", r, bus_b.runs, exp_runs); end
         n_tests++; if (busy_cyc != 2 || done_cyc != 1) begin
            n_fail++; $display("FAIL sat_held run %0d: got busy %0d done %0d expected 2 1", r, busy_cyc, done_cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_normal_run();
      test_abort();
      test_simultaneous();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Upstream control stage for the team's free-running N-bit counter.
- Turns a raw, bouncy push-button into a clean registered start level, which drives the counter's start input.
- Monitors the counter's output (fed back as count_in) and ends the run automatically when it reaches a programmed limit.
- Supports manual abort and reports completion, abort and a run tally.

Parameters:
- N, 8, width of count_in; must match the downstream counter width.
- DEB_CYCLES, 4, consecutive stable cycles required before the debounced button level changes; legal range 1..255.
- LIMIT, 200, counter value that ends a run; legal range 1..2^N-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw asynchronous push-button, active-high.
- count_in  input  N  current counter value from the downstream counter.
- start  output  1  registered run level to the counter's start input.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  sticky flag: the last run was ended by a button press.
- runs  output  8  number of completed, non-aborted runs; saturates at 255.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0, the FSM goes to IDLE, and the synchronizer, debounce counter, btn_db and btn_db_d all clear to 0.
  - Release is sampled on clk.
- Synchronizer: two flops on btn (s1, then s2). s2 is the only use of btn.
- Debounce:
  - An 8-bit counter increments each cycle that s2 != btn_db and clears to 0 when s2 == btn_db.
  - When the counter equals DEB_CYCLES-1 and s2 != btn_db at an edge, btn_db takes s2 and the counter clears.
  - press = btn_db & ~btn_db_d, where btn_db_d is btn_db delayed one cycle.
- Press timing:
  - If btn is first sampled high at edge k and held, btn_db rises at edge k+DEB_CYCLES+1.
  - press is evaluated at edge k+DEB_CYCLES+2, so start rises after that edge.
- FSM states: IDLE, RUN, DONE, ABORT.
  - IDLE: start=0, busy=0. On press, go to RUN and clear aborted.
  - RUN: start=1, busy=1.
    - If count_in == LIMIT, go to DONE. This takes priority over press in the same cycle.
    - Else if press, go to ABORT.
    - Otherwise stay in RUN.
  - DONE: start=0, done=1 for exactly this one cycle, runs increments (saturating at 255). Unconditionally go to IDLE.
  - ABORT: start=0, aborted set to 1. Unconditionally go to IDLE; runs is unchanged.
- start, busy and done are registered, decoded from next-state; there are no combinational paths from inputs to outputs.
- The counter clears when start=0, so count_in returns to 0 one cycle after start falls. This block does not depend on that.
- A press arriving in DONE or ABORT is lost. The button must be released and re-pressed to start again, because press is edge-based.
- A button held continuously produces exactly one press.
- Glitches shorter than DEB_CYCLES cycles, as seen at s2, never change btn_db.
- count_in is compared only in RUN. A count_in value above LIMIT never matches, so the run continues until the value equals LIMIT, or until abort.
- Reset asserted during RUN: start drops immediately, since reset is asynchronous, and runs and aborted clear.

Test Plan:
- Reset values: assert rst_n=0 mid-RUN with count_in=37 -> start, busy, done, aborted and runs go to 0 immediately; after release the FSM is in IDLE.
- Debounce timing (DEB_CYCLES=4): btn rises before edge k and is held -> start=1 after edge k+6; a 3-cycle btn high pulse -> start stays 0.
- Normal run (LIMIT=200, bench counter model driven by start): press -> count_in ramps 0..200. At the edge where count_in=200, go to DONE: done=1 for one cycle, start=0, runs goes 0->1, aborted=0.
- Abort: press, then at count_in=50 issue a second clean press -> ABORT, start=0, aborted=1, runs unchanged. The next press starts a new run and clears aborted.
- Simultaneous events: a second press whose debounced edge coincides with count_in==LIMIT -> DONE taken, runs increments, aborted stays 0.
- Saturation: 256 complete runs (use LIMIT=1 for speed) -> runs reads 255 after runs 255 and 256. A held button across a DONE does not restart a run.
